// File: rtl/ps2_scancode_rx_if.sv
// PS/2 receiver pin and event bundle: raw pins in, decoded key event and diagnostics out.
interface ps2_scancode_rx_if;
  logic        ps2_clk;
  logic        ps2_data;
  logic [10:0] ps2_key;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        frame_err;

  modport master (
    output ps2_clk, ps2_data,
    input  ps2_key, rx_byte, rx_valid, frame_err
  );

  modport slave (
    input  ps2_clk, ps2_data,
    output ps2_key, rx_byte, rx_valid, frame_err
  );
endinterface

// File: rtl/ps2_scancode_rx.sv
// PS/2 set-2 keyboard receiver: synchronizes and deglitches the pins, frames bytes on
// ps2_clk falling edges, folds E0/F0 prefixes into an 11-bit {strobe, break, ext, code} event.
module ps2_scancode_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic               clk,
  input  logic               reset,
  ps2_scancode_rx_if.slave   bus
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic          r_clk_s1, r_clk_s2, r_clk_f, r_clk_fd;
  logic          r_dat_s1, r_dat_s2, r_dat_f;
  logic [FW-1:0] r_clk_cnt, r_dat_cnt;
  logic          w_fall;

  state_t        r_state;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_par;
  logic [TW-1:0] r_to_cnt;
  logic          r_ext_pend, r_brk_pend;
  logic [10:0]   r_ps2_key;
  logic [7:0]    r_rx_byte;
  logic          r_rx_valid, r_frame_err;

  // A filtered line only follows the synchronized pin after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_clk_s1  <= 1'b1;
      r_clk_s2  <= 1'b1;
      r_clk_f   <= 1'b1;
      r_clk_fd  <= 1'b1;
      r_clk_cnt <= '0;
      r_dat_s1  <= 1'b1;
      r_dat_s2  <= 1'b1;
      r_dat_f   <= 1'b1;
      r_dat_cnt <= '0;
    end else begin
      r_clk_s1 <= bus.ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= bus.ps2_data;
      r_dat_s2 <= r_dat_s1;
      r_clk_fd <= r_clk_f;

      if (r_clk_s2 == r_clk_f) begin
        r_clk_cnt <= '0;
      end else if (r_clk_cnt == FW'(FILTER_LEN - 1)) begin
        r_clk_f   <= r_clk_s2;
        r_clk_cnt <= '0;
      end else begin
        r_clk_cnt <= r_clk_cnt + 1'b1;
      end

      if (r_dat_s2 == r_dat_f) begin
        r_dat_cnt <= '0;
      end else if (r_dat_cnt == FW'(FILTER_LEN - 1)) begin
        r_dat_f   <= r_dat_s2;
        r_dat_cnt <= '0;
      end else begin
        r_dat_cnt <= r_dat_cnt + 1'b1;
      end
    end
  end

  assign w_fall = r_clk_fd & ~r_clk_f;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_par       <= 1'b0;
      r_to_cnt    <= '0;
      r_ext_pend  <= 1'b0;
      r_brk_pend  <= 1'b0;
      r_ps2_key   <= '0;
      r_rx_byte   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_rx_valid    <= 1'b0;
      r_frame_err   <= 1'b0;
      r_ps2_key[10] <= 1'b0;

      // An edge always wins over a timeout expiring in the same cycle.
      if (w_fall) begin
        r_to_cnt <= '0;
        case (r_state)
          S_IDLE: begin
            if (!r_dat_f) begin
              r_state   <= S_DATA;
              r_bit_cnt <= '0;
            end
          end
          S_DATA: begin
            r_shift   <= {r_dat_f, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) r_state <= S_PARITY;
          end
          S_PARITY: begin
            r_par   <= r_dat_f;
            r_state <= S_STOP;
          end
          S_STOP: begin
            r_state <= S_IDLE;
            if (r_dat_f && (^{r_shift, r_par})) begin
              r_rx_valid <= 1'b1;
              r_rx_byte  <= r_shift;
              case (r_shift)
                8'hE0: r_ext_pend <= 1'b1;
                8'hF0: r_brk_pend <= 1'b1;
                8'hE1: ;
                8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: begin
                  r_ext_pend <= 1'b0;
                  r_brk_pend <= 1'b0;
                end
                default: begin
                  r_ps2_key  <= {1'b1, r_brk_pend, r_ext_pend, r_shift};
                  r_ext_pend <= 1'b0;
                  r_brk_pend <= 1'b0;
                end
              endcase
            end else begin
              r_frame_err <= 1'b1;
              r_ext_pend  <= 1'b0;
              r_brk_pend  <= 1'b0;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end else if (r_state != S_IDLE) begin
        if (r_to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          r_state     <= S_IDLE;
          r_to_cnt    <= '0;
          r_frame_err <= 1'b1;
          r_ext_pend  <= 1'b0;
          r_brk_pend  <= 1'b0;
        end else begin
          r_to_cnt <= r_to_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.ps2_key   = r_ps2_key;
  assign bus.rx_byte   = r_rx_byte;
  assign bus.rx_valid  = r_rx_valid;
  assign bus.frame_err = r_frame_err;

endmodule
